// File: rtl/mdiv_pkg.sv
// Shared constants and types for the modular-inverse / modular-division datapath.
package mdiv_pkg;

  localparam int unsigned MDIV_WORD_W = 32;
  localparam int unsigned MDIV_NWORDS = 8;
  localparam int unsigned MDIV_OPND_W = MDIV_WORD_W * MDIV_NWORDS;
  localparam int unsigned MDIV_IDX_W  = $clog2(MDIV_NWORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } mdiv_ser_state_t;

endpackage

// File: rtl/mdiv_word_mux.sv
// NWORDS:1 word selector over a flat operand, indexed by physical word number.
module mdiv_word_mux
  import mdiv_pkg::*;
#(
  parameter int unsigned WORD_W = MDIV_WORD_W,
  parameter int unsigned NWORDS = MDIV_NWORDS
) (
  input  logic [WORD_W*NWORDS-1:0]  data,
  input  logic [$clog2(NWORDS)-1:0] idx,
  output logic [WORD_W-1:0]         word_c
);

  localparam int unsigned IDX_W = $clog2(NWORDS);

  always_comb begin
    word_c = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (idx == IDX_W'(i)) word_c = data[i*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/mdiv_word_ser.sv
// Parallel-in, serial-out word serializer: captures one operand, streams it
// as NWORDS words over a valid/ready bus with fully registered outputs.
module mdiv_word_ser
  import mdiv_pkg::*;
#(
  parameter int unsigned WORD_W    = MDIV_WORD_W,
  parameter int unsigned NWORDS    = MDIV_NWORDS,
  parameter bit          MSW_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [WORD_W*NWORDS-1:0]   ld_data,
  output logic                       wd_valid,
  input  logic                       wd_ready,
  output logic [WORD_W-1:0]          wd_data,
  output logic                       wd_last,
  output logic [$clog2(NWORDS)-1:0]  wd_idx,
  output logic                       busy,
  input  logic                       abort
);

  localparam int unsigned IDX_W  = $clog2(NWORDS);
  localparam int unsigned OPND_W = WORD_W * NWORDS;
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NWORDS - 1);

  // Index-based muxing relies on a full, power-of-two counter range.
  if (NWORDS < 2 || (NWORDS & (NWORDS - 1)) != 0) begin : g_bad_nwords
    $error("mdiv_word_ser: NWORDS must be a power of two and at least 2");
  end

  mdiv_ser_state_t   state_q, state_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;
  logic [IDX_W-1:0]  phys_d;
  logic [WORD_W-1:0] word_d;
  logic              xfer;

  logic              ld_ready_d, wd_valid_d, busy_d, wd_last_d;
  logic [WORD_W-1:0] wd_data_d;
  logic [IDX_W-1:0]  wd_idx_d;

  assign xfer   = wd_valid && wd_ready;
  assign phys_d = MSW_FIRST ? (LAST_CNT - count_d) : count_d;

  // Word for the next cycle is selected from the next-state operand so the
  // first word is already registered on the cycle after the load.
  mdiv_word_mux #(
    .WORD_W (WORD_W),
    .NWORDS (NWORDS)
  ) u_mux (
    .data   (opnd_d),
    .idx    (phys_d),
    .word_c (word_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      opnd_q   <= '0;
      ld_ready <= 1'b1;
      wd_valid <= 1'b0;
      busy     <= 1'b0;
      wd_data  <= '0;
      wd_idx   <= '0;
      wd_last  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      opnd_q   <= opnd_d;
      ld_ready <= ld_ready_d;
      wd_valid <= wd_valid_d;
      busy     <= busy_d;
      wd_data  <= wd_data_d;
      wd_idx   <= wd_idx_d;
      wd_last  <= wd_last_d;
    end
  end

  // Abort wins over both load and transfer.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    opnd_d  = opnd_q;
    unique case (state_q)
      IDLE: begin
        if (abort) begin
          count_d = '0;
        end else if (ld_valid) begin
          opnd_d  = ld_data;
          count_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (xfer) begin
          if (count_q == LAST_CNT) begin
            count_d = '0;
            state_d = IDLE;
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ld_ready_d = (state_d == IDLE);
    wd_valid_d = (state_d == SEND);
    busy_d     = (state_d == SEND);
    wd_data_d  = '0;
    wd_idx_d   = '0;
    wd_last_d  = 1'b0;
    if (state_d == SEND) begin
      wd_data_d = word_d;
      wd_idx_d  = phys_d;
      wd_last_d = (count_d == LAST_CNT);
    end
  end

endmodule

// File: tb/tb_mdiv_word_ser.sv
// Directed bench for mdiv_word_ser: LSW-first and MSW-first instances share
// one set of inputs and are checked against hand-computed words.
module tb_mdiv_word_ser;

  localparam logic [255:0] OPND_A =
    256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
  localparam logic [255:0] OPND_B = {256{1'b1}};

  logic         clk;
  logic         rst_n;
  logic         ld_valid;
  logic [255:0] ld_data;
  logic         wd_ready;
  logic         abort;

  logic         ld_ready0, wd_valid0, wd_last0, busy0;
  logic [31:0]  wd_data0;
  logic [2:0]   wd_idx0;
  logic         ld_ready1, wd_valid1, wd_last1, busy1;
  logic [31:0]  wd_data1;
  logic [2:0]   wd_idx1;

  int n_chk;
  int n_pass;

  mdiv_word_ser #(.WORD_W(32), .NWORDS(8), .MSW_FIRST(1'b0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready0),
    .ld_data  (ld_data),
    .wd_valid (wd_valid0),
    .wd_ready (wd_ready),
    .wd_data  (wd_data0),
    .wd_last  (wd_last0),
    .wd_idx   (wd_idx0),
    .busy     (busy0),
    .abort    (abort)
  );

  mdiv_word_ser #(.WORD_W(32), .NWORDS(8), .MSW_FIRST(1'b1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready1),
    .ld_data  (ld_data),
    .wd_valid (wd_valid1),
    .wd_ready (wd_ready),
    .wd_data  (wd_data1),
    .wd_last  (wd_last1),
    .wd_idx   (wd_idx1),
    .busy     (busy1),
    .abort    (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operand A word i is the nibble (i+1) replicated eight times.
  function automatic logic [31:0] word_a(input int i);
    return 32'h11111111 * 32'(i + 1);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".ld_ready"}, 64'(ld_ready0), 64'd1);
    check({tag, ".wd_valid"}, 64'(wd_valid0), 64'd0);
    check({tag, ".busy"},     64'(busy0),     64'd0);
    check({tag, ".wd_idx"},   64'(wd_idx0),   64'd0);
    check({tag, ".wd_last"},  64'(wd_last0),  64'd0);
  endtask

  initial begin
    int got_words;
    int cyc;
    logic rdy;

    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    ld_valid = 1'b0;
    ld_data = '0;
    wd_ready = 1'b0;
    abort = 1'b0;

    #12;
    check_idle("reset");
    check("reset.wd_data", 64'(wd_data0), 64'd0);
    check("reset.msw_ready", 64'(ld_ready1), 64'd1);
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Full-rate streaming, both word orders.
    ld_valid = 1'b1;
    ld_data  = OPND_A;
    wd_ready = 1'b1;
    tick();
    ld_valid = 1'b0;
    check("full.ld_ready", 64'(ld_ready0), 64'd0);
    check("full.busy", 64'(busy0), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full.valid%0d", i), 64'(wd_valid0), 64'd1);
      check($sformatf("full.data%0d", i), 64'(wd_data0), 64'(word_a(i)));
      check($sformatf("full.idx%0d", i), 64'(wd_idx0), 64'(i));
      check($sformatf("full.last%0d", i), 64'(wd_last0), 64'(i == 7));
      check($sformatf("msw.data%0d", i), 64'(wd_data1), 64'(word_a(7 - i)));
      check($sformatf("msw.idx%0d", i), 64'(wd_idx1), 64'(7 - i));
      check($sformatf("msw.last%0d", i), 64'(wd_last1), 64'(i == 7));
      tick();
    end
    check_idle("full_done");
    check("msw_done.valid", 64'(wd_valid1), 64'd0);

    // Backpressure with ready pattern 1,0,0,1,0,0,...
    ld_valid = 1'b1;
    ld_data  = OPND_A;
    wd_ready = 1'b0;
    tick();
    ld_valid = 1'b0;
    got_words = 0;
    cyc = 0;
    while (got_words < 8 && cyc < 40) begin
      check($sformatf("bp.valid%0d", cyc), 64'(wd_valid0), 64'd1);
      check($sformatf("bp.data%0d", cyc), 64'(wd_data0), 64'(word_a(got_words)));
      check($sformatf("bp.idx%0d", cyc), 64'(wd_idx0), 64'(got_words));
      check($sformatf("bp.ld_ready%0d", cyc), 64'(ld_ready0), 64'd0);
      rdy = (cyc % 3 == 0);
      wd_ready = rdy;
      tick();
      if (rdy) got_words++;
      cyc++;
    end
    check("bp.words", 64'(got_words), 64'd8);
    check("bp.cycles", 64'(cyc), 64'd22);
    check_idle("bp_done");

    // Load blocking: second operand held on ld_data for the whole stream.
    ld_valid = 1'b1;
    ld_data  = OPND_A;
    wd_ready = 1'b1;
    tick();
    ld_data = OPND_B;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("blk.data%0d", i), 64'(wd_data0), 64'(word_a(i)));
      check($sformatf("blk.ld_ready%0d", i), 64'(ld_ready0), 64'd0);
      tick();
    end
    check("blk.bubble_valid", 64'(wd_valid0), 64'd0);
    check("blk.bubble_ready", 64'(ld_ready0), 64'd1);
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("blk2.valid%0d", i), 64'(wd_valid0), 64'd1);
      check($sformatf("blk2.data%0d", i), 64'(wd_data0), 64'hFFFFFFFF);
      check($sformatf("blk2.idx%0d", i), 64'(wd_idx0), 64'(i));
      check($sformatf("blk2.last%0d", i), 64'(wd_last0), 64'(i == 7));
      tick();
    end
    check_idle("blk_done");

    // Abort at word 4 while stalled.
    ld_valid = 1'b1;
    ld_data  = OPND_A;
    wd_ready = 1'b1;
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort.idx_before", 64'(wd_idx0), 64'd4);
    check("abort.data_before", 64'(wd_data0), 64'(word_a(4)));
    wd_ready = 1'b0;
    abort = 1'b1;
    tick();
    check_idle("abort");
    check("abort.msw_valid", 64'(wd_valid1), 64'd0);
    ld_valid = 1'b1;
    tick();
    check("abort_vs_load.valid", 64'(wd_valid0), 64'd0);
    check("abort_vs_load.ready", 64'(ld_ready0), 64'd1);
    abort = 1'b0;
    tick();
    ld_valid = 1'b0;
    wd_ready = 1'b1;
    check("reload.valid", 64'(wd_valid0), 64'd1);
    check("reload.idx", 64'(wd_idx0), 64'd0);
    check("reload.data", 64'(wd_data0), 64'(word_a(0)));
    check("reload.msw_idx", 64'(wd_idx1), 64'd7);
    for (int i = 0; i < 8; i++) tick();
    check_idle("reload_done");

    // Asynchronous reset in the middle of a stream at word 3.
    ld_valid = 1'b1;
    ld_data  = OPND_A;
    wd_ready = 1'b1;
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("areset.idx_before", 64'(wd_idx0), 64'd3);
    wd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle("areset");
    check("areset.wd_data", 64'(wd_data0), 64'd0);
    check("areset.msw_busy", 64'(busy1), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    check_idle("areset_release");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
